// File: rtl/tape_save.sv
// tape_save: TAP image writer.
// Reads N bytes of Lynx RAM from base A (save_load for 'M', 0x694D otherwise)
// and streams a TAP file: 22 22 type Llo Lhi [Alo Ahi] data.. [C] [Elo Ehi].
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   save_start/type/len/load/exec start command and file parameters
//   mem_rd, mem_addr, mem_din    single-port RAM read (data one cycle after strobe)
//   out_valid/ready/data/last    byte stream to the upload path
//   busy, done, err              status (done/err are one-cycle pulses)
module tape_save (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        save_start,
    input  logic [7:0]  save_type,
    input  logic [15:0] save_len,
    input  logic [15:0] save_load,
    input  logic [15:0] save_exec,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_RD, S_WT, S_DAT, S_TRL, S_EXL, S_EXH, S_DONE
    } state_t;

    localparam logic [7:0] T_B = 8'h42;
    localparam logic [7:0] T_M = 8'h4D;
    localparam logic [7:0] T_D = 8'h44;
    localparam logic [7:0] T_A = 8'h41;

    state_t      r_state, w_next;
    logic [7:0]  r_type;
    logic [15:0] r_len, r_rem, r_addr, r_exec;
    logic [7:0]  r_sum;
    logic [2:0]  r_idx;
    logic [7:0]  r_out_data;
    logic        r_out_valid, r_out_last, r_err;

    logic        w_legal, w_is_m, w_is_b, w_hs;
    logic [2:0]  w_hdr_last, w_hidx;
    logic [7:0]  w_hdr_byte;
    logic [15:0] w_lfield;

    assign w_legal    = (save_type == T_B || save_type == T_M ||
                         save_type == T_D || save_type == T_A) && (save_len != 16'd0);
    assign w_is_m     = (r_type == T_M);
    assign w_is_b     = (r_type == T_B);
    assign w_hs       = r_out_valid & out_ready;
    assign w_hdr_last = w_is_m ? 3'd6 : 3'd4;
    assign w_hidx     = r_idx + 3'd1;
    assign w_lfield   = r_len - 16'd1;

    // Next header byte. r_addr still equals the base address while in HDR,
    // since it only advances once reads begin.
    always_comb begin
        w_hdr_byte = 8'h22;
        case (w_hidx)
            3'd2:    w_hdr_byte = r_type;
            3'd3:    w_hdr_byte = w_lfield[7:0];
            3'd4:    w_hdr_byte = w_lfield[15:8];
            3'd5:    w_hdr_byte = r_addr[7:0];
            3'd6:    w_hdr_byte = r_addr[15:8];
            default: w_hdr_byte = 8'h22;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (save_start && w_legal) w_next = S_HDR;
            S_HDR:  if (w_hs && r_idx == w_hdr_last) w_next = S_RD;
            S_RD:   w_next = S_WT;
            S_WT:   w_next = S_DAT;
            S_DAT:  if (w_hs) begin
                        if (r_rem != 16'd1) w_next = S_RD;
                        else if (w_is_b)    w_next = S_DONE;
                        else                w_next = S_TRL;
                    end
            S_TRL:  if (w_hs) w_next = w_is_m ? S_EXL : S_DONE;
            S_EXL:  if (w_hs) w_next = S_EXH;
            S_EXH:  if (w_hs) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mem_rd = (r_state == S_RD);
        busy   = (r_state != S_IDLE) && (r_state != S_DONE);
        done   = (r_state == S_DONE);
    end

    // Datapath: latched command, address/count, checksum and the output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_type      <= 8'h00;
            r_len       <= 16'h0000;
            r_rem       <= 16'h0000;
            r_addr      <= 16'h0000;
            r_exec      <= 16'h0000;
            r_sum       <= 8'h00;
            r_idx       <= 3'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (save_start) begin
                    if (w_legal) begin
                        r_type      <= save_type;
                        r_len       <= save_len;
                        r_rem       <= save_len;
                        r_exec      <= save_exec;
                        r_addr      <= (save_type == T_M) ? save_load : 16'h694D;
                        r_sum       <= 8'h00;
                        r_idx       <= 3'd0;
                        r_out_data  <= 8'h22;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_HDR: if (w_hs) begin
                    if (r_idx == w_hdr_last) begin
                        r_out_valid <= 1'b0;
                    end else begin
                        r_idx      <= w_hidx;
                        r_out_data <= w_hdr_byte;
                    end
                end
                S_RD: r_addr <= r_addr + 16'd1;   // 16-bit wrap is intended
                S_WT: begin
                    r_out_data  <= mem_din;
                    r_sum       <= r_sum + mem_din;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_is_b && (r_rem == 16'd1);
                end
                S_DAT: if (w_hs) begin
                    r_rem <= r_rem - 16'd1;
                    if (r_rem != 16'd1 || w_is_b) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else begin
                        // Checksum follows directly; for 'M' it is not the last byte
                        r_out_data <= r_sum;
                        r_out_last <= !w_is_m;
                    end
                end
                S_TRL: if (w_hs) begin
                    if (w_is_m) begin
                        r_out_data <= r_exec[7:0];
                        r_out_last <= 1'b0;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                S_EXL: if (w_hs) begin
                    r_out_data <= r_exec[15:8];
                    r_out_last <= 1'b1;
                end
                S_EXH: if (w_hs) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign err       = r_err;
endmodule
